// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver control path.
// The state enum, the default frame width and the accepted oversampling ratios live here.
package uart_rx_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    ERR_CHK = 3'd5
  } rx_state_e;

  function automatic logic prescale_legal(input logic [5:0] ps);
    return (ps == PRESCALE_8) || (ps == PRESCALE_16) || (ps == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample (edge) and frame-bit counters for the UART receiver.
// Clear wins over the load-to-one used for back-to-back frames, which wins over counting.
module uart_rx_edge_bit_counter (
  input  logic       clk,
  input  logic       RST,
  input  logic       cnt_clr,
  input  logic       cnt_load_one,
  input  logic       cnt_en,
  input  logic [5:0] prescale_lat,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       end_of_bit
);

  assign end_of_bit = cnt_en && (edge_cnt == (prescale_lat - 6'd1));

  always_ff @(posedge clk) begin
    if (!RST) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (cnt_clr) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (cnt_load_one) begin
      edge_cnt <= 6'd1;
      bit_cnt  <= 4'd0;
    end else if (cnt_en) begin
      if (end_of_bit) begin
        edge_cnt <= 6'd0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver frame controller: walks start/data/parity/stop bits, fires the checker strobes
// and decides frame acceptance from the checker results.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       Rx_in,
  input  logic       PAR_EN,
  input  logic [5:0] prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       DATA_Valid,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  rx_state_e  state;
  logic [5:0] ps_lat;
  logic       par_en_lat;
  logic       glitch_flag;
  logic       par_flag;
  logic       stp_flag;

  logic [5:0] mid;
  logic [5:0] edge_nxt;
  logic       active;
  logic       end_of_bit;
  logic       chk_cycle;
  logic       glitch_now;
  logic       stp_now;
  logic       frame_stop;
  logic       cnt_clr;
  logic       cnt_load_one;
  logic       samp_nxt;
  logic       strobe_nxt;

  assign state_dbg = state;

  assign mid      = {1'b0, ps_lat[5:1]};
  assign edge_nxt = edge_cnt + 6'd1;
  assign active   = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);

  // Checker results arrive one cycle after the strobe at mid+2; for prescale 8 that
  // cycle is also the last oversample of the bit, so the live result is folded in.
  assign chk_cycle  = active && (edge_cnt == (mid + 6'd3));
  assign glitch_now = glitch_flag || ((state == START) && chk_cycle && strt_glitch);
  assign stp_now    = stp_flag || ((state == STOP) && chk_cycle && stp_err);

  assign frame_stop   = end_of_bit && ((state == STOP) || ((state == START) && glitch_now));
  assign cnt_clr      = (state == IDLE) || ((state == ERR_CHK) && Rx_in) || frame_stop;
  assign cnt_load_one = (state == ERR_CHK) && !Rx_in;

  // Outputs are registered, so they are decided one oversample early; the window and
  // strobe never straddle a bit boundary for the legal ratios.
  assign samp_nxt   = active && !end_of_bit &&
                      (edge_nxt >= (mid - 6'd1)) && (edge_nxt <= (mid + 6'd1));
  assign strobe_nxt = active && (edge_cnt == (mid + 6'd1));

  uart_rx_edge_bit_counter u_cnt (
    .clk          (clk),
    .RST          (RST),
    .cnt_clr      (cnt_clr),
    .cnt_load_one (cnt_load_one),
    .cnt_en       (active),
    .prescale_lat (ps_lat),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .end_of_bit   (end_of_bit)
  );

  always_ff @(posedge clk) begin
    if (!RST) begin
      state       <= IDLE;
      ps_lat      <= 6'd0;
      par_en_lat  <= 1'b0;
      glitch_flag <= 1'b0;
      par_flag    <= 1'b0;
      stp_flag    <= 1'b0;
      dat_samp_en <= 1'b0;
      deser_en    <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      DATA_Valid  <= 1'b0;
    end else begin
      dat_samp_en <= samp_nxt;
      strt_chk_en <= strobe_nxt && (state == START);
      deser_en    <= strobe_nxt && (state == DATA);
      par_chk_en  <= strobe_nxt && (state == PARITY);
      stp_chk_en  <= strobe_nxt && (state == STOP);
      DATA_Valid  <= 1'b0;

      if (chk_cycle) begin
        case (state)
          START:   glitch_flag <= strt_glitch;
          PARITY:  par_flag    <= par_flag | par_err;
          STOP:    stp_flag    <= stp_flag | stp_err;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (!Rx_in && prescale_legal(prescale)) begin
            ps_lat      <= prescale;
            par_en_lat  <= PAR_EN;
            glitch_flag <= 1'b0;
            par_flag    <= 1'b0;
            stp_flag    <= 1'b0;
            state       <= START;
          end
        end
        START: begin
          if (end_of_bit) state <= glitch_now ? IDLE : DATA;
        end
        DATA: begin
          if (end_of_bit && (bit_cnt == LAST_DATA_BIT)) state <= par_en_lat ? PARITY : STOP;
        end
        PARITY: begin
          if (end_of_bit) state <= STOP;
        end
        STOP: begin
          if (end_of_bit) begin
            state      <= ERR_CHK;
            DATA_Valid <= !(par_flag || stp_now);
          end
        end
        ERR_CHK: begin
          // A low line here is already the first oversample of the next start bit.
          if (!Rx_in) begin
            glitch_flag <= 1'b0;
            par_flag    <= 1'b0;
            stp_flag    <= 1'b0;
            state       <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: per-cycle expectations derived from frame arithmetic
// (bit = offset / prescale, oversample = offset % prescale) plus literal timing pins.
module tb_uart_rx_fsm;

  localparam int DW = 8;
  localparam logic [15:0] FULL  = 16'hFFFF;
  localparam logic [15:0] NOCNT = 16'h003F;

  logic       clk = 1'b0;
  logic       RST;
  logic       Rx_in;
  logic       PAR_EN;
  logic [5:0] prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       DATA_Valid;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  int valid_cnt, valid_cyc, deser_cnt, par_cnt, strt_cnt, t_start;
  logic [31:0] cur;
  logic [15:0] act;

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .RST         (RST),
    .Rx_in       (Rx_in),
    .PAR_EN      (PAR_EN),
    .prescale    (prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .DATA_Valid  (DATA_Valid),
    .state_dbg   (state_dbg)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard compare and output monitors
  always @(negedge clk) begin
    act = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, DATA_Valid};
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checks++;
      if ((act & cur[31:16]) !== (cur[15:0] & cur[31:16])) begin
        errors++;
        $display("FAIL outputs cycle %0d act=%h exp=%h mask=%h", cyc, act, cur[15:0], cur[31:16]);
      end
    end
    if (DATA_Valid === 1'b1) begin valid_cnt++; valid_cyc = cyc; end
    if (deser_en === 1'b1) deser_cnt++;
    if (par_chk_en === 1'b1) par_cnt++;
    if (strt_chk_en === 1'b1) strt_cnt++;
  end

  function automatic logic [15:0] pk(input int e, input int b, input bit s, input bit d,
                                     input bit sc, input bit pc, input bit tc, input bit v);
    return {6'(e), 4'(b), s, d, sc, pc, tc, v};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] jps();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic check_int(input string name, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, a, e);
    end
  endtask

  task automatic clear_mon();
    valid_cnt = 0; valid_cyc = -1; deser_cnt = 0; par_cnt = 0; strt_cnt = 0;
  endtask

  // driver: apply inputs for this cycle, queue this cycle's expected outputs
  task automatic step(input logic rx, input logic [5:0] ps, input logic pe, input logic sg,
                      input logic pr, input logic sp, input logic [15:0] e, input logic [15:0] m);
    Rx_in = rx; prescale = ps; PAR_EN = pe; strt_glitch = sg; par_err = pr; stp_err = sp;
    exp_q.push_back({m, e});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, jps(), rb(), rb(), rb(), rb(), 16'h0, FULL);
  endtask

  task automatic illegal_low(input int n);
    logic [5:0] ps;
    for (int i = 0; i < n; i++) begin
      if (i == 0) ps = 6'd12;
      else begin
        do ps = jps(); while (ps == 6'd8 || ps == 6'd16 || ps == 6'd32);
      end
      step(1'b0, ps, rb(), rb(), rb(), rb(), 16'h0, FULL);
    end
  endtask

  // One frame; offset 0 is the first START oversample (or the ERR_CHK cycle when back-to-back).
  task automatic do_frame(input int p, input bit pe, input logic [7:0] data, input bit gl,
                          input bit perr, input bit serr, input bit b2b_in, input bit b2b_out,
                          input int abort_idx);
    int mid, nb, b, e, first;
    bit is_dat, is_par, is_stp, rx, sg, pr, sp;
    mid = p / 2;
    nb  = gl ? 1 : DW + 2 + (pe ? 1 : 0);
    if (!b2b_in) begin
      t_start = cyc;
      step(1'b0, 6'(p), pe, rb(), rb(), rb(), 16'h0, FULL);
    end
    first = b2b_in ? 1 : 0;
    for (int idx = first; idx < nb * p; idx++) begin
      b = idx / p;
      e = idx % p;
      is_dat = (b >= 1) && (b <= DW);
      is_par = pe && (b == DW + 1);
      is_stp = !gl && (b == nb - 1);
      if (b == 0) rx = gl ? (idx >= 1) : 1'b0;
      else if (is_dat) rx = data[b-1];
      else if (is_par) rx = ^data;
      else rx = 1'b1;
      sg = (b == 0 && e == mid + 3) ? gl : rb();
      pr = (is_par && e == mid + 3) ? perr : rb();
      sp = (is_stp && e == mid + 3) ? serr : rb();
      if (idx == abort_idx) RST = 1'b0;
      step(rx, jps(), rb(), sg, pr, sp,
           pk(e, b, (e >= mid - 1) && (e <= mid + 1), is_dat && (e == mid + 2),
              (b == 0) && (e == mid + 2), is_par && (e == mid + 2), is_stp && (e == mid + 2), 1'b0),
           FULL);
      if (idx == abort_idx) begin
        RST = 1'b1;
        return;
      end
    end
    if (!gl)
      step(!b2b_out, jps(), rb(), rb(), rb(), rb(),
           pk(0, 0, 0, 0, 0, 0, 0, !(pe && perr) && !serr), NOCNT);
  endtask

  initial begin
    int p;
    bit pe, gl, b2b, nb2b;
    RST = 1'b0; Rx_in = 1'b1; PAR_EN = 1'b0; prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b1;
    step(1'b1, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, FULL);
    idle(3);

    // 0xA5, prescale 8, no parity: valid at T+81, eight deser strobes
    clear_mon();
    do_frame(8, 0, 8'hA5, 0, 0, 0, 0, 0, -1);
    check_int("valid_offset_np", valid_cyc - t_start, 81);
    check_int("deser_pulses_np", deser_cnt, 8);
    check_int("valid_count_np", valid_cnt, 1);
    idle(3);

    // with parity, no error: valid at T+89, one parity strobe
    clear_mon();
    do_frame(8, 1, 8'hA5, 0, 0, 0, 0, 0, -1);
    check_int("valid_offset_par", valid_cyc - t_start, 89);
    check_int("par_pulses", par_cnt, 1);
    idle(2);

    // parity error rejects the frame
    clear_mon();
    do_frame(8, 1, 8'hA5, 0, 1, 0, 0, 0, -1);
    check_int("valid_count_perr", valid_cnt, 0);
    idle(3);

    // start glitch at prescale 16: back to IDLE after 16 START cycles
    clear_mon();
    do_frame(16, 0, 8'h00, 1, 0, 0, 0, 0, -1);
    check_int("glitch_deser", deser_cnt, 0);
    check_int("glitch_valid", valid_cnt, 0);
    check_int("glitch_strt", strt_cnt, 1);
    idle(3);

    // stop error, then back-to-back frame that completes
    clear_mon();
    do_frame(8, 0, 8'h3C, 0, 0, 1, 0, 1, -1);
    check_int("serr_valid", valid_cnt, 0);
    do_frame(8, 0, 8'hC3, 0, 0, 0, 1, 0, -1);
    check_int("b2b_valid", valid_cnt, 1);
    idle(2);

    // reset mid-DATA at bit 4, then illegal prescale with line low stays IDLE
    do_frame(8, 0, 8'h5A, 0, 0, 0, 0, 0, 4 * 8 + 3);
    illegal_low(5);
    idle(2);

    // start accepted in the very first cycle after reset release
    RST = 1'b0;
    step(1'b1, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, FULL);
    RST = 1'b1;
    clear_mon();
    do_frame(8, 0, 8'h81, 0, 0, 0, 0, 0, -1);
    check_int("valid_offset_after_rst", valid_cyc - t_start, 81);
    idle(2);

    // randomized frames
    b2b = 1'b0; p = 8; pe = 1'b0;
    for (int f = 0; f < 25; f++) begin
      if (!b2b) begin
        p  = 8 << $urandom_range(0, 2);
        pe = rb();
      end
      gl   = ($urandom_range(0, 4) == 0);
      nb2b = !gl && (f != 24) && ($urandom_range(0, 2) == 0);
      do_frame(p, pe, 8'($urandom), gl, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
               b2b, nb2b, -1);
      b2b = nb2b;
      if (!b2b) idle($urandom_range(1, 4));
    end

    @(negedge clk);
    check_int("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
